// File: rtl/rs_pkg.sv
// Shared constants and scheduler state type for the RS decoder syndrome/BM path.
package rs_pkg;

  localparam int SYN_W = 128;
  localparam int GF_W  = 8;
  localparam int NSYM  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rs_rr_arbiter.sv
// Round-robin request picker: first asserted request at or after ptr, wrapping.
module rs_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rs_bm_scheduler.sv
// Shares one Berlekamp-Massey engine among NUM_REQ syndrome producers, with
// zero-syndrome bypass, tagged result hold and a hang timeout.
//
// state | meaning
// IDLE  | waiting for a syndrome while the engine is free; grant happens here
// ISSUE | one-cycle start pulse to the engine, timeout counter loaded
// WAIT  | waiting for the engine strobe or timeout terminal count
// HOLD  | result presented until the consumer takes it
module rs_bm_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int SYN_W   = rs_pkg::SYN_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*SYN_W-1:0]   req_syn,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [SYN_W-1:0]           bm_data_in,
  output logic                       bm_valid_in,
  input  logic [SYN_W-1:0]           bm_poly_out,
  input  logic                       bm_valid_out,
  input  logic                       bm_busy,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [SYN_W-1:0]           rsp_poly,
  output logic                       rsp_err
);

  import rs_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t state, state_nx;

  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [SYN_W-1:0]   gnt_syn;
  logic               syn_zero;
  logic               grant_go;
  logic               tmo_hit;

  rs_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign gnt_syn  = req_syn[int'(gnt_idx)*SYN_W +: SYN_W];
  assign syn_zero = (gnt_syn == '0);
  assign tmo_hit  = (tmo_cnt == '0);

  always_comb begin
    state_nx    = state;
    req_ready   = '0;
    grant_go    = 1'b0;
    bm_valid_in = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any && !bm_busy) begin
          grant_go  = 1'b1;
          req_ready = gnt;
          state_nx  = syn_zero ? HOLD : ISSUE;
        end
      end
      ISSUE: begin
        bm_valid_in = 1'b1;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (bm_valid_out || tmo_hit) state_nx = HOLD;
      end
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
      bm_data_in <= '0;
      rsp_id     <= '0;
      rsp_poly   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant_go) begin
            bm_data_in <= gnt_syn;
            rsp_id     <= gnt_idx;
            // A zero syndrome means no errors: locator is the constant 1.
            if (syn_zero) rsp_poly <= SYN_W'(1);
          end
        end
        ISSUE: tmo_cnt <= CNT_W'(TIMEOUT - 1);
        WAIT: begin
          if (!tmo_hit) tmo_cnt <= tmo_cnt - CNT_W'(1);
          if (bm_valid_out) begin
            rsp_poly <= bm_poly_out;
            rsp_err  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_poly <= '0;
            rsp_err  <= 1'b1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rr_ptr  <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
            rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_bm_scheduler.sv
// Self-checking bench for rs_bm_scheduler with a programmable-delay engine stub.
module tb_rs_bm_scheduler;

  localparam int NUM_REQ = 4;
  localparam int SYN_W   = 128;
  localparam int TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*SYN_W-1:0] req_syn;
  logic [NUM_REQ-1:0]       req_ready;
  logic [SYN_W-1:0]         bm_data_in;
  logic                     bm_valid_in;
  logic [SYN_W-1:0]         bm_poly_out;
  logic                     bm_valid_out;
  logic                     bm_busy;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic [SYN_W-1:0]         rsp_poly;
  logic                     rsp_err;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;
  int issue_cnt = 0;

  // Engine stub: strobes a result stub_delay+2 cycles after the issue pulse.
  logic             stub_pend = 1'b0;
  int               stub_cnt = 0;
  logic             stub_vo = 1'b0;
  logic [SYN_W-1:0] stub_poly = '0;
  int               stub_delay = 0;
  bit               stub_hang = 1'b0;
  logic             force_vo = 1'b0;
  logic [SYN_W-1:0] force_poly = '0;

  always #5 clk = ~clk;

  rs_bm_scheduler #(
    .NUM_REQ (NUM_REQ),
    .SYN_W   (SYN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_syn      (req_syn),
    .req_ready    (req_ready),
    .bm_data_in   (bm_data_in),
    .bm_valid_in  (bm_valid_in),
    .bm_poly_out  (bm_poly_out),
    .bm_valid_out (bm_valid_out),
    .bm_busy      (bm_busy),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_poly     (rsp_poly),
    .rsp_err      (rsp_err)
  );

  function automatic logic [SYN_W-1:0] eng(input logic [SYN_W-1:0] s);
    return {s[119:0], s[127:120]} ^ 128'h0123456789abcdef_fedcba9876543210;
  endfunction

  function automatic logic [SYN_W-1:0] rand_syn();
    return {$urandom, $urandom, $urandom, $urandom} | 128'h1;
  endfunction

  function automatic int pick(input logic [3:0] m, input int p);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (p + k) % NUM_REQ;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    stub_vo <= 1'b0;
    if (bm_valid_in && !stub_pend && !stub_hang) begin
      stub_pend <= 1'b1;
      stub_cnt  <= stub_delay;
      stub_poly <= eng(bm_data_in);
    end else if (stub_pend) begin
      if (stub_cnt == 0) begin
        stub_vo   <= 1'b1;
        stub_pend <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (bm_valid_in === 1'b1) issue_cnt <= issue_cnt + 1;

  assign bm_valid_out = stub_vo | force_vo;
  assign bm_poly_out  = force_vo ? force_poly : stub_poly;
  assign bm_busy      = stub_pend;

  task automatic set_syn(input int i, input logic [SYN_W-1:0] v);
    req_syn[i*SYN_W +: SYN_W] = v;
  endtask

  // Drops req_valid after the accept edge and waits (bounded) for rsp_valid.
  task automatic wait_rsp(input int limit, output int n);
    @(negedge clk);
    req_valid = '0;
    #1;
    n = 1;
    while (!rsp_valid && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_syn = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({req_ready, bm_valid_in, rsp_valid, rsp_err, rsp_id} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy=%b vin=%b rv=%b err=%b id=%0d want all 0",
               req_ready, bm_valid_in, rsp_valid, rsp_err, rsp_id);
    end
    n_vec++;
    if (bm_data_in !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", bm_data_in);
    end
    n_vec++;
    if (rsp_poly !== '0) begin
      n_err++; $display("FAIL reset_poly: got %h want 0", rsp_poly);
    end
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int ng, exp_i;
    logic [3:0] prev, exp_oh;
    for (int i = 0; i < NUM_REQ; i++) set_syn(i, rand_syn());
    stub_delay = 1;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'hf;
    prev = '0;
    ng = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready !== 4'b0000) begin
        exp_i  = pick(4'hf, m_ptr);
        exp_oh = 4'b0001 << exp_i;
        n_vec++;
        if (req_ready !== exp_oh) begin
          n_err++; $display("FAIL rr_order: grant %0d req_ready=%b want %b", ng, req_ready, exp_oh);
        end
        n_vec++;
        if (prev !== 4'b0000) begin
          n_err++; $display("FAIL rr_one_cycle: req_ready=%b prev=%b want prev 0000", req_ready, prev);
        end
        m_ptr = (exp_i + 1) % NUM_REQ;
        ng++;
      end
      prev = req_ready;
    end
    n_vec++;
    if (ng != 5) begin
      n_err++; $display("FAIL rr_count: saw %0d grants want 5", ng);
    end
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (rsp_valid) break;
      @(negedge clk);
    end
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      n_err++; $display("FAIL rr_last_rsp: rv=%b id=%0d want rv=1 id=0", rsp_valid, rsp_id);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_single();
    logic [SYN_W-1:0] syn;
    int n, i0;
    syn = 128'h0000804020100804028080201008_0402;
    stub_delay = 3;
    set_syn(0, syn);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    i0 = issue_cnt;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL single_grant: req_ready=%b want 0001", req_ready);
    end
    wait_rsp(100, n);
    n_vec++;
    if (rsp_valid !== 1'b1 || n != stub_delay + 4) begin
      n_err++; $display("FAIL single_latency: rv=%b cycles=%0d want rv=1 cycles=%0d", rsp_valid, n, stub_delay + 4);
    end
    n_vec++;
    if (issue_cnt - i0 != 1) begin
      n_err++; $display("FAIL single_issue: pulses=%0d want 1", issue_cnt - i0);
    end
    n_vec++;
    if (rsp_id !== 2'd0 || rsp_err !== 1'b0 || rsp_poly !== eng(syn)) begin
      n_err++; $display("FAIL single_rsp: id=%0d err=%b poly=%h want id=0 err=0 poly=%h", rsp_id, rsp_err, rsp_poly, eng(syn));
    end
    n_vec++;
    if (bm_data_in !== syn) begin
      n_err++; $display("FAIL single_data: bm_data_in=%h want %h", bm_data_in, syn);
    end
    handshake();
    m_ptr = 1;
  endtask

  task automatic test_zero_syn();
    int n, i0;
    set_syn(2, '0);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    i0 = issue_cnt;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL zero_grant: req_ready=%b want 0100", req_ready);
    end
    wait_rsp(10, n);
    n_vec++;
    if (rsp_valid !== 1'b1 || n != 1) begin
      n_err++; $display("FAIL zero_latency: rv=%b cycles=%0d want rv=1 cycles=1", rsp_valid, n);
    end
    n_vec++;
    if (rsp_poly !== 128'h1 || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL zero_rsp: poly=%h id=%0d err=%b want poly=1 id=2 err=0", rsp_poly, rsp_id, rsp_err);
    end
    handshake();
    n_vec++;
    if (issue_cnt != i0) begin
      n_err++; $display("FAIL zero_no_issue: pulses=%0d want 0", issue_cnt - i0);
    end
    m_ptr = 3;
  endtask

  task automatic test_timeout();
    int n;
    stub_hang = 1'b1;
    set_syn(1, rand_syn());
    @(negedge clk);
    req_valid = 4'b0010;
    wait_rsp(100, n);
    // accept -> issue (1) -> first wait cycle (1) -> TIMEOUT wait cycles
    n_vec++;
    if (rsp_valid !== 1'b1 || n != TIMEOUT + 2) begin
      n_err++; $display("FAIL tmo_latency: rv=%b cycles=%0d want rv=1 cycles=%0d", rsp_valid, n, TIMEOUT + 2);
    end
    n_vec++;
    if (rsp_err !== 1'b1 || rsp_poly !== '0 || rsp_id !== 2'd1) begin
      n_err++; $display("FAIL tmo_rsp: err=%b poly=%h id=%0d want err=1 poly=0 id=1", rsp_err, rsp_poly, rsp_id);
    end
    handshake();
    stub_hang = 1'b0;
    m_ptr = 2;
    #1;
    n_vec++;
    if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL tmo_clear: err=%b rv=%b want 0 0", rsp_err, rsp_valid);
    end
    @(negedge clk);
    force_poly = rand_syn();
    force_vo = 1'b1;
    @(negedge clk);
    force_vo = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (rsp_valid !== 1'b0 || rsp_poly !== '0) begin
        n_err++; $display("FAIL tmo_late_ignored: rv=%b poly=%h want rv=0 poly=0", rsp_valid, rsp_poly);
      end
    end
  endtask

  task automatic test_boundary();
    logic [SYN_W-1:0] syn;
    int n;
    // Delay 14: strobe lands on the last wait cycle and must win over the timeout.
    syn = rand_syn();
    stub_delay = 14;
    set_syn(3, syn);
    @(negedge clk);
    req_valid = 4'b1000;
    wait_rsp(100, n);
    n_vec++;
    if (n != TIMEOUT + 2 || rsp_err !== 1'b0 || rsp_poly !== eng(syn)) begin
      n_err++; $display("FAIL edge_win: cycles=%0d err=%b poly=%h want cycles=%0d err=0 poly=%h",
                        n, rsp_err, rsp_poly, TIMEOUT + 2, eng(syn));
    end
    handshake();
    m_ptr = 0;
    // Delay 15: strobe arrives one cycle too late, already in HOLD.
    syn = rand_syn();
    stub_delay = 15;
    set_syn(0, syn);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_rsp(100, n);
    n_vec++;
    if (n != TIMEOUT + 2 || rsp_err !== 1'b1 || rsp_poly !== '0) begin
      n_err++; $display("FAIL edge_late: cycles=%0d err=%b poly=%h want cycles=%0d err=1 poly=0",
                        n, rsp_err, rsp_poly, TIMEOUT + 2);
    end
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_poly !== '0) begin
      n_err++; $display("FAIL edge_hold_ignore: rv=%b err=%b poly=%h want 1 1 0", rsp_valid, rsp_err, rsp_poly);
    end
    handshake();
    m_ptr = 1;
  endtask

  task automatic test_backpressure();
    logic [SYN_W-1:0] syn, syn1;
    int n, bad;
    syn  = rand_syn();
    syn1 = rand_syn();
    stub_delay = 2;
    set_syn(0, syn);
    set_syn(1, syn1);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_rsp(100, n);
    req_valid = 4'b1110;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || req_ready !== 4'b0000 || rsp_id !== 2'd0 ||
          rsp_err !== 1'b0 || rsp_poly !== eng(syn)) begin
        n_err++; bad++;
        if (bad < 4)
          $display("FAIL hold_stable: cycle %0d rv=%b rdy=%b id=%0d err=%b poly=%h want 1 0000 0 0 %h",
                   c, rsp_valid, req_ready, rsp_id, rsp_err, rsp_poly, eng(syn));
      end
    end
    m_ptr = 1;
    handshake();
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== (4'b0001 << pick(4'b1110, m_ptr))) begin
      n_err++; $display("FAIL hold_release: rv=%b rdy=%b want rv=0 rdy=%b",
                        rsp_valid, req_ready, 4'b0001 << pick(4'b1110, m_ptr));
    end
    wait_rsp(100, n);
    n_vec++;
    if (rsp_id !== 2'd1 || rsp_poly !== eng(syn1)) begin
      n_err++; $display("FAIL hold_next: id=%0d poly=%h want id=1 poly=%h", rsp_id, rsp_poly, eng(syn1));
    end
    handshake();
    m_ptr = 2;
  endtask

  task automatic test_reset_mid();
    logic [SYN_W-1:0] syn;
    int n, bad;
    stub_delay = 10;
    set_syn(2, rand_syn());
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if ({req_ready, bm_valid_in, rsp_valid, rsp_err, rsp_id} !== '0 || bm_data_in !== '0 || rsp_poly !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: rdy=%b vin=%b rv=%b err=%b id=%0d data=%h poly=%h want all 0",
                        req_ready, bm_valid_in, rsp_valid, rsp_err, rsp_id, bm_data_in, rsp_poly);
    end
    rst = 1'b0;
    m_ptr = 0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0 || rsp_poly !== '0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_mid_late_ignored: %0d cycles with rv/poly set want 0", bad);
    end
    syn = rand_syn();
    for (int i = 0; i < NUM_REQ; i++) set_syn(i, rand_syn());
    set_syn(0, syn);
    @(negedge clk);
    req_valid = 4'hf;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rst_mid_rr0: req_ready=%b want 0001", req_ready);
    end
    wait_rsp(100, n);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_poly !== eng(syn)) begin
      n_err++; $display("FAIL rst_mid_serve: rv=%b id=%0d poly=%h want 1 0 %h", rsp_valid, rsp_id, rsp_poly, eng(syn));
    end
    handshake();
    m_ptr = 1;
  endtask

  task automatic test_random();
    logic [3:0]       mask, exp_oh;
    logic [SYN_W-1:0] syn [NUM_REQ];
    logic [SYN_W-1:0] exp_poly;
    int g, d, n, i0, exp_n;
    bit zero;
    for (int r = 0; r < 30; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) syn[i] = rand_syn();
      g = pick(mask, m_ptr);
      zero = ($urandom_range(0, 3) == 0);
      if (zero) syn[g] = '0;
      for (int i = 0; i < NUM_REQ; i++) set_syn(i, syn[i]);
      d = $urandom_range(0, 5);
      stub_delay = d;
      exp_oh   = 4'b0001 << g;
      exp_poly = zero ? 128'h1 : eng(syn[g]);
      exp_n    = zero ? 1 : d + 4;
      @(negedge clk);
      req_valid = mask;
      #1;
      i0 = issue_cnt;
      n_vec++;
      if (req_ready !== exp_oh) begin
        n_err++; $display("FAIL rand_grant: round %0d mask=%b req_ready=%b want %b", r, mask, req_ready, exp_oh);
      end
      wait_rsp(60, n);
      n_vec++;
      if (rsp_valid !== 1'b1 || n != exp_n || rsp_id !== 2'(g) || rsp_err !== 1'b0 || rsp_poly !== exp_poly) begin
        n_err++; $display("FAIL rand_rsp: round %0d rv=%b cyc=%0d id=%0d err=%b poly=%h want 1 %0d %0d 0 %h",
                          r, rsp_valid, n, rsp_id, rsp_err, rsp_poly, exp_n, g, exp_poly);
      end
      n_vec++;
      if (issue_cnt - i0 != (zero ? 0 : 1)) begin
        n_err++; $display("FAIL rand_issue: round %0d pulses=%0d want %0d", r, issue_cnt - i0, zero ? 0 : 1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
      m_ptr = (g + 1) % NUM_REQ;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_syn();
    test_timeout();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
